// File: rtl/sccb_config_writer.sv
// SCCB configuration writer: walks the camera config table and sends each
// address/value pair to the OV7670 as a 3-phase SCCB write, stopping at 0xFF/0xFF.
module sccb_config_writer #(
    parameter int          CLK_DIV    = 30,
    parameter int          RESET_WAIT = 12000,
    parameter logic [7:0]  DEV_ID     = 8'h42
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       START,
    input  logic [7:0] CTRL_ADDR,
    input  logic [7:0] CTRL_VALUE,
    output logic       START_CONFIG,
    output logic       NEXT,
    output logic       SIOC,
    output logic       SIOD_OUT,
    output logic       SIOD_OE,
    output logic       BUSY,
    output logic       DONE
);

    typedef enum logic [3:0] {
        IDLE, REWIND, STROBE, SETTLE, CHECK, SEND, HOLD, ADVANCE, FINISH
    } state_t;

    localparam int              CNT_MAX      = (RESET_WAIT > CLK_DIV) ? RESET_WAIT : CLK_DIV;
    localparam int              CW           = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]   Q_LAST       = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   WAIT_LAST    = CW'(RESET_WAIT - 1);
    localparam logic [6:0]      QUARTER_LAST = 7'd114;
    // The ninth bit of each byte is released so the camera may drive its ACK.
    localparam logic [26:0]     OE_MASK      = 27'b111111110_111111110_111111110;

    state_t          state, next_state;
    logic [CW-1:0]   cnt;
    logic [6:0]      quarter;
    logic [7:0]      entry;
    logic [15:0]     hold_reg;
    logic            busy_q, done_q;

    logic            frame_done;
    logic            soft_reset;
    logic [26:0]     frame_bits;
    logic [6:0]      bit_q;
    logic [4:0]      bit_idx;
    logic [1:0]      bit_sub;

    assign frame_done = (quarter == QUARTER_LAST) && (cnt == Q_LAST);
    assign soft_reset = (hold_reg[15:8] == 8'h12) && hold_reg[7];
    assign frame_bits = {DEV_ID, 1'b1, hold_reg[15:8], 1'b1, hold_reg[7:0], 1'b1};
    assign bit_q      = quarter - 7'd1;
    assign bit_idx    = bit_q[6:2];
    assign bit_sub    = bit_q[1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= '0;
            quarter  <= '0;
            entry    <= '0;
            hold_reg <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state <= next_state;
            // Counters restart on every state change; SEND counts quarter periods.
            if (next_state != state || state == IDLE) begin
                cnt     <= '0;
                quarter <= '0;
            end else if (state == SEND && cnt == Q_LAST) begin
                cnt     <= '0;
                quarter <= quarter + 7'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (state == IDLE && START) begin
                busy_q <= 1'b1;
                done_q <= 1'b0;
                entry  <= '0;
            end
            if (state == ADVANCE)
                entry <= entry + 8'd1;
            if (state == CHECK)
                hold_reg <= {CTRL_ADDR, CTRL_VALUE};
            if (next_state == FINISH) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state   = state;
        START_CONFIG = 1'b0;
        NEXT         = 1'b0;
        SIOC         = 1'b1;
        SIOD_OUT     = 1'b1;
        SIOD_OE      = 1'b1;
        case (state)
            IDLE:    if (START) next_state = REWIND;
            REWIND: begin
                START_CONFIG = 1'b1;
                next_state   = STROBE;
            end
            STROBE: begin
                NEXT = 1'b1;
                // Entry 0 is only ever strobed straight after a rewind.
                START_CONFIG = (entry == 8'd0);
                if (cnt == CW'(1)) next_state = SETTLE;
            end
            SETTLE:  if (cnt == CW'(1)) next_state = CHECK;
            CHECK:   next_state = ({CTRL_ADDR, CTRL_VALUE} == 16'hFFFF) ? FINISH : SEND;
            SEND: begin
                if (quarter == 7'd0) begin
                    SIOD_OUT = 1'b0;
                end else if (quarter <= 7'd108) begin
                    SIOC     = (bit_sub >= 2'd2);
                    SIOD_OUT = frame_bits[5'd26 - bit_idx];
                    SIOD_OE  = OE_MASK[5'd26 - bit_idx];
                end else if (quarter == 7'd109) begin
                    SIOC     = 1'b0;
                    SIOD_OUT = 1'b0;
                end else if (quarter == 7'd110) begin
                    SIOD_OUT = 1'b0;
                end
                if (frame_done) next_state = soft_reset ? HOLD : ADVANCE;
            end
            HOLD:    if (cnt == WAIT_LAST) next_state = ADVANCE;
            ADVANCE: next_state = (entry == 8'hFF) ? FINISH : STROBE;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule
